// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM request arbiter slice.
//   SDRAM_AW / SDRAM_DW   : default word address / data widths
//   SDRAM_ACC_TIMEOUT     : default cycles allowed for m_busy to rise
//   state_t               : arbiter FSM state encoding
//   op_t                  : latched operation kind (read / write)
// ---------------------------------------------------------------------------
package sdram_pkg;

   localparam int SDRAM_AW          = 24;
   localparam int SDRAM_DW          = 16;
   localparam int SDRAM_ACC_TIMEOUT = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      D_ISSUE  = 3'd1,
      D_WAIT   = 3'd2,
      I_ISSUE0 = 3'd3,
      I_WAIT0  = 3'd4,
      I_ISSUE1 = 3'd5,
      I_WAIT1  = 3'd6
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   // True for any state that issues a request pulse to the controller.
   function automatic logic isIssueState(input state_t s);
      return (s == D_ISSUE) || (s == I_ISSUE0) || (s == I_ISSUE1);
   endfunction

   // True for any state that is waiting on the controller's busy handshake.
   function automatic logic isWaitState(input state_t s);
      return (s == D_WAIT) || (s == I_WAIT0) || (s == I_WAIT1);
   endfunction

endpackage

// File: rtl/sdram_busy_tracker.sv
// ---------------------------------------------------------------------------
// sdram_busy_tracker
// Follows the controller's m_busy after a request pulse and reports when the
// access has finished or when the controller never picked it up.
//   clk, rst    : clock, asynchronous active-high reset
//   i_start     : high during the request pulse cycle; re-arms the tracker
//   i_active    : high while the arbiter waits for this access
//   i_busy      : controller busy
//   o_done      : busy was seen and has now dropped (completion cycle)
//   o_timeout   : busy never rose within ACC_TIMEOUT wait cycles
// ---------------------------------------------------------------------------
module sdram_busy_tracker
   import sdram_pkg::*;
#(
   parameter int ACC_TIMEOUT = SDRAM_ACC_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   input  logic i_active,
   input  logic i_busy,
   output logic o_done,
   output logic o_timeout
);

   localparam int CW = $clog2(ACC_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(ACC_TIMEOUT - 1);

   logic          r_seen;
   logic [CW-1:0] r_count;

   // The tracker is cleared by the request pulse so that the first wait cycle
   // sees a count of zero. While waiting it either notes that busy has risen
   // (phase B from then on) or counts another idle cycle. The counter saturates
   // at its last value because the FSM leaves the wait state on timeout anyway.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seen  <= 1'b0;
         r_count <= '0;
      end else if (i_start) begin
         r_seen  <= 1'b0;
         r_count <= '0;
      end else if (i_active && !r_seen) begin
         if (i_busy) begin
            r_seen <= 1'b1;
         end else if (r_count != LAST_COUNT) begin
            r_count <= r_count + CW'(1);
         end
      end
   end

   // Completion is the first non-busy cycle after busy was seen; timeout is
   // the last allowed wait cycle still passing without busy.
   always_comb begin
      o_done    = i_active && r_seen && !i_busy;
      o_timeout = i_active && !r_seen && !i_busy && (r_count == LAST_COUNT);
   end

endmodule

// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
// Merges the CPU instruction-fetch port and the data port onto the SDRAM
// controller's single request interface. Data accesses are one 16-bit word;
// a fetch is two consecutive single-word reads returned as one 32-bit word.
//   clk, rst                 : clock, asynchronous active-high reset
//   i_addr/i_req             : fetch request (held until i_ack)
//   i_ack/i_data             : fetch completion pulse and 32-bit instruction
//   d_addr/d_wdata           : data address and write data
//   d_read/d_write           : data request (held until d_ack)
//   d_ack/d_rdata            : data completion pulse and read data
//   m_addr/m_wdata           : controller address / write data (held)
//   m_read_req/m_write_req   : controller request pulses
//   m_rdata/m_busy           : controller read data and busy
//   err                      : sticky lost-transaction flag
// ---------------------------------------------------------------------------
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int AW          = SDRAM_AW,
   parameter int DW          = SDRAM_DW,
   parameter int ACC_TIMEOUT = SDRAM_ACC_TIMEOUT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   i_addr,
   input  logic            i_req,
   output logic            i_ack,
   output logic [2*DW-1:0] i_data,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic            d_read,
   input  logic            d_write,
   output logic            d_ack,
   output logic [DW-1:0]   d_rdata,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   output logic            m_read_req,
   output logic            m_write_req,
   input  logic [DW-1:0]   m_rdata,
   input  logic            m_busy,
   output logic            err
);

   state_t            r_state;
   state_t            w_nextState;
   op_t               r_op;
   logic [AW-1:0]     r_mAddr;
   logic [DW-1:0]     r_mWdata;
   logic [2*DW-1:0]   r_iData;
   logic [DW-1:0]     r_dRdata;
   logic              r_iAck;
   logic              r_dAck;
   logic              r_err;

   logic              w_sampleOk;
   logic              w_dReq;
   logic              w_dSel;
   logic              w_iSel;
   logic              w_start;
   logic              w_active;
   logic              w_done;
   logic              w_timeout;
   logic              w_mReadReq;
   logic              w_mWriteReq;

   // Requests are only looked at in IDLE, and not during the ack cycle:
   // the requester still holds its request while the ack is visible, so
   // sampling then would serve the same request a second time.
   always_comb begin
      w_sampleOk = !r_iAck && !r_dAck;
      w_dReq     = d_read || d_write;
      w_dSel     = (r_state == IDLE) && w_sampleOk && w_dReq;
      w_iSel     = (r_state == IDLE) && w_sampleOk && i_req && !w_dReq;
   end

   sdram_busy_tracker #(
      .ACC_TIMEOUT (ACC_TIMEOUT)
   ) u_busyTracker (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_start),
      .i_active  (w_active),
      .i_busy    (m_busy),
      .o_done    (w_done),
      .o_timeout (w_timeout)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. Each issue state lasts a single cycle; each wait state
   // leaves on completion, or on timeout straight back to IDLE without an ack.
   // A fetch always runs both halves before IDLE is seen again, so a data
   // request arriving mid-fetch simply waits.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_dSel) begin
               w_nextState = D_ISSUE;
            end else if (w_iSel) begin
               w_nextState = I_ISSUE0;
            end
         end
         D_ISSUE:  w_nextState = D_WAIT;
         D_WAIT: begin
            if (w_timeout || w_done) begin
               w_nextState = IDLE;
            end
         end
         I_ISSUE0: w_nextState = I_WAIT0;
         I_WAIT0: begin
            if (w_timeout) begin
               w_nextState = IDLE;
            end else if (w_done) begin
               w_nextState = I_ISSUE1;
            end
         end
         I_ISSUE1: w_nextState = I_WAIT1;
         I_WAIT1: begin
            if (w_timeout || w_done) begin
               w_nextState = IDLE;
            end
         end
         default:  w_nextState = IDLE;
      endcase
   end

   // Output decode. The request pulses come straight from the issue states,
   // which are one cycle long, so each pulse is exactly one cycle wide.
   always_comb begin
      w_mReadReq  = ((r_state == D_ISSUE) && (r_op == OP_RD))
                    || (r_state == I_ISSUE0) || (r_state == I_ISSUE1);
      w_mWriteReq = (r_state == D_ISSUE) && (r_op == OP_WR);
      w_start     = isIssueState(r_state);
      w_active    = isWaitState(r_state);
   end

   // Datapath registers. Address, write data and op are captured when a
   // request is selected and then held until the next selection, which keeps
   // m_addr/m_wdata stable through the whole access and leaves the last
   // values on the bus while idle. The second fetch half reuses the address
   // register incremented by one, wrapping naturally at the top of the space.
   // Acks are registered so they appear the cycle after completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op     <= OP_RD;
         r_mAddr  <= '0;
         r_mWdata <= '0;
         r_iData  <= '0;
         r_dRdata <= '0;
         r_iAck   <= 1'b0;
         r_dAck   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_dAck <= (r_state == D_WAIT) && w_done;
         r_iAck <= (r_state == I_WAIT1) && w_done;

         if (w_timeout) begin
            r_err <= 1'b1;
         end

         if (w_dSel) begin
            r_op     <= d_write ? OP_WR : OP_RD;
            r_mAddr  <= d_addr;
            r_mWdata <= d_wdata;
         end else if (w_iSel) begin
            r_op    <= OP_RD;
            r_mAddr <= i_addr;
         end

         if ((r_state == D_WAIT) && w_done && (r_op == OP_RD)) begin
            r_dRdata <= m_rdata;
         end

         if ((r_state == I_WAIT0) && w_done) begin
            r_iData[2*DW-1:DW] <= m_rdata;
            r_mAddr            <= r_mAddr + AW'(1);
         end

         if ((r_state == I_WAIT1) && w_done) begin
            r_iData[DW-1:0] <= m_rdata;
         end
      end
   end

   // Port hookup.
   always_comb begin
      i_ack       = r_iAck;
      i_data      = r_iData;
      d_ack       = r_dAck;
      d_rdata     = r_dRdata;
      m_addr      = r_mAddr;
      m_wdata     = r_mWdata;
      m_read_req  = w_mReadReq;
      m_write_req = w_mWriteReq;
      err         = r_err;
   end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Upstream neighbour of the SDRAM controller: merges the CPU instruction-fetch port and data port onto the controller's single request interface (m_*). Data accesses are 16-bit single words. Each instruction fetch is two consecutive 16-bit reads, never a burst, returned as one 32-bit word. Holds address and write data stable for the full transaction and tracks completion via m_busy.

Parameters:
AW, 24, word address width shared with the SDRAM controller
DW, 16, SDRAM data word width
ACC_TIMEOUT, 8, max cycles after a request pulse for m_busy to rise before a transaction is declared lost

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
i_addr  in  AW  instruction word address (first half)
i_req  in  1  fetch request, held until i_ack
i_ack  out  1  one-cycle pulse, i_data valid this cycle
i_data  out  2*DW  fetched instruction, [31:16]=word@i_addr, [15:0]=word@i_addr+1
d_addr  in  AW  data word address
d_wdata  in  DW  write data
d_read  in  1  data read request, held until d_ack
d_write  in  1  data write request, held until d_ack
d_ack  out  1  one-cycle completion pulse
d_rdata  out  DW  read data, valid with d_ack on reads
m_addr  out  AW  controller address
m_wdata  out  DW  controller write data
m_read_req  out  1  controller read request pulse
m_write_req  out  1  controller write request pulse
m_rdata  in  DW  controller read data
m_busy  in  1  controller busy
err  out  1  sticky lost-transaction flag

Behaviour:
- Reset (async, rst=1): state IDLE; i_ack, d_ack, m_read_req, m_write_req, err = 0; m_addr, m_wdata, i_data, d_rdata = 0. Reset mid-transaction abandons it; no ack issued.
- States: IDLE, D_ISSUE, D_WAIT, I_ISSUE0, I_WAIT0, I_ISSUE1, I_WAIT1.
- IDLE: requests sampled only here. Priority: d_read/d_write over i_req. d_read and d_write both high -> treated as write. Latch address, wdata and op at selection; go to D_ISSUE or I_ISSUE0. Requests are not re-sampled until the cycle after the ack.
- *_ISSUE: m_addr/m_wdata driven from latched values. The matching m_*_req is high for exactly one cycle. Go to the matching WAIT state.
- *_WAIT phase A: wait for m_busy=1. Counter starts at 0 in the cycle after the pulse. If m_busy is not seen by ACC_TIMEOUT cycles: set err, return to IDLE, no ack.
- *_WAIT phase B: after m_busy=1 is seen, the first cycle with m_busy=0 completes the access. Capture m_rdata in that cycle.
- D_WAIT completion: d_ack=1 next cycle; d_rdata updated on reads only. Return to IDLE.
- I_WAIT0 completion: store into i_data[31:16]; go to I_ISSUE1 with address i_addr+1 (mod 2^AW, so 0xFFFFFF wraps to 0x000000).
- I_WAIT1 completion: store into i_data[15:0]; i_ack=1 next cycle; return to IDLE.
- A pending data request never preempts an in-progress fetch; it is served on the next IDLE.
- Latency with zero controller busy time: data op = issue(1) + wait(≥2) + ack(1). Fetch = 2× the issue+wait sequence, plus the ack.
- m_addr and m_wdata are stable from issue through completion. Idle values of m_addr/m_wdata hold the last transaction's values.
- Refresh: the controller keeps m_busy high through refresh, which the arbiter absorbs transparently.
- err clears only on rst.

Decomposition:
- Shared package sdram_pkg: AW/DW constants, state encoding enum, op encoding (OP_RD, OP_WR).
- One sub-module: sdram_busy_tracker (watches m_busy after a pulse; outputs done/timeout; instantiated once and restarted per access).

Test Plan:
- Data write d_addr=0x000123, d_wdata=0xBEEF, m_busy high 3 cycles → one m_write_req pulse; m_addr=0x000123 and m_wdata=0xBEEF stable until completion; d_ack one cycle; no i_ack.
- Fetch i_addr=0x0000FF, model returns 0x1234 then 0x5678 → m_addr 0x0000FF then 0x000100; i_data=0x12345678 with i_ack.
- Simultaneous d_read(0x10) and i_req(0x20) in IDLE → data read served first, then fetch; d_read asserted during the fetch waits for i_ack.
- Fetch at i_addr=0xFFFFFF → second read at 0x000000.
- m_busy never rises after a request → err=1 after ACC_TIMEOUT=8 cycles; IDLE; no ack. Next request proceeds normally with err still 1.
- rst pulsed during I_WAIT1 → all outputs 0 immediately; no i_ack. Fresh i_req after release completes correctly.
